// File: rtl/prog_counter.sv
// Parametrised up/down counter with prescaled enable, clear, clamped load,
// wrap/saturate boundary handling, terminal-count pulse and sticky overflow.
module prog_counter #(
  parameter int WIDTH    = 16,
  parameter int MOD_MAX  = 2**WIDTH-1,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MOD_MAX);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;

  // Loaded values above the terminal value are clamped so Q never leaves 0..MOD_MAX.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    psc_d = psc_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    step  = 1'b0;
    if (clr) begin
      cnt_d = '0;
      psc_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = clamp_load(load_val);
      psc_d = '0;
    end else if (en) begin
      if (psc_q == PSC_LAST) begin
        psc_d = '0;
        step  = 1'b1;
      end else begin
        psc_d = psc_q + PSC_W'(1);
      end
    end

    // Boundary events wrap to the opposite end of 0..MOD_MAX or hold in saturate mode.
    if (step) begin
      if (up) begin
        if (cnt_q == MAX_V) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          cnt_d = (SATURATE != 0) ? MAX_V : '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          cnt_d = (SATURATE != 0) ? '0 : MAX_V;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      psc_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      psc_q <= psc_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: three WIDTH=4, MOD_MAX=9 instances (wrap, saturate,
// prescale-3) share one stimulus stream and are checked against a reference model.
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [3:0] lv = '0;
  logic [3:0] q_w, q_s, q_p;
  logic       tc_w, tc_s, tc_p, ovf_w, ovf_s, ovf_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv), .Q(q_w), .tc(tc_w), .ovf(ovf_w));
  prog_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv), .Q(q_s), .tc(tc_s), .ovf(ovf_s));
  prog_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(0), .PRESCALE(3)) u_psc (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv), .Q(q_p), .tc(tc_p), .ovf(ovf_p));

  // Reference model: counter value as an integer in 0..9, boundary found by range check.
  localparam int MAXV = 9;
  int mq[3], mp[3], mt[3], mo[3];
  int sat_k[3] = '{0, 1, 0};
  int pre_k[3] = '{1, 1, 3};

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = 0; mp[k] = 0; mt[k] = 0; mo[k] = 0;
    end
  endtask

  task automatic model_edge();
    int nq;
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        mq[k] = 0; mp[k] = 0; mt[k] = 0; mo[k] = 0;
      end else if (clr) begin
        mq[k] = 0; mp[k] = 0; mt[k] = 0; mo[k] = 0;
      end else if (load) begin
        mq[k] = (int'(lv) > MAXV) ? MAXV : int'(lv);
        mp[k] = 0; mt[k] = 0;
      end else begin
        mt[k] = 0;
        if (en) begin
          mp[k] = mp[k] + 1;
          if (mp[k] == pre_k[k]) begin
            mp[k] = 0;
            nq = up ? mq[k] + 1 : mq[k] - 1;
            if (nq < 0 || nq > MAXV) begin
              mt[k] = 1; mo[k] = 1;
              nq = (sat_k[k] != 0) ? mq[k] : (up ? 0 : MAXV);
            end
            mq[k] = nq;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("wrap.Q", int'(q_w), mq[0]); chk("wrap.tc", int'(tc_w), mt[0]); chk("wrap.ovf", int'(ovf_w), mo[0]);
    chk("sat.Q", int'(q_s), mq[1]);  chk("sat.tc", int'(tc_s), mt[1]);  chk("sat.ovf", int'(ovf_s), mo[1]);
    chk("psc.Q", int'(q_p), mq[2]);  chk("psc.tc", int'(tc_p), mt[2]);  chk("psc.ovf", int'(ovf_p), mo[2]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic u, input logic [3:0] v);
    clr = c; load = l; en = e; up = u; lv = v;
  endtask

  typedef struct {
    logic       clr, load, en, up;
    logic [3:0] lv;
    int         q, tc, ovf;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // Directed vectors for the wrap instance: {clr, load, en, up, load_val} -> {Q, tc, ovf}
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd8,  8, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  9, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  0, 1, 1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1, 0, 1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1,  1, 0, 1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  0, 0, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  9, 1, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  8, 0, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  0, 0, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  0, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1, 0, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd12, 9, 0, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  0, 1, 1};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 9, 0, 1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  9, 0, 1};

    model_reset();
    #2;
    check_all();
    tick();
    tick();
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].lv);
      tick();
      chk($sformatf("tbl[%0d].Q", i),   int'(q_w),   tbl[i].q);
      chk($sformatf("tbl[%0d].tc", i),  int'(tc_w),  tbl[i].tc);
      chk($sformatf("tbl[%0d].ovf", i), int'(ovf_w), tbl[i].ovf);
    end

    // Saturate: hold at 9 with tc high on every step edge, then step down.
    drive(1, 0, 0, 1, 0); tick();
    drive(0, 1, 0, 1, 9); tick();
    chk("sat.load9", int'(q_s), 9);
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat.hold.Q", int'(q_s), 9);
      chk("sat.hold.tc", int'(tc_s), 1);
      chk("sat.hold.ovf", int'(ovf_s), 1);
    end
    drive(0, 0, 1, 0, 0); tick();
    chk("sat.down.Q", int'(q_s), 8);
    chk("sat.down.tc", int'(tc_s), 0);

    // Prescale by 3: 9 enabled edges give 3 steps; gaps in en keep the phase.
    drive(1, 0, 0, 1, 0); tick();
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 9; i++) tick();
    chk("psc.nine", int'(q_p), 3);
    tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("psc.gap", int'(q_p), 3);
    en = 1'b1; tick();
    chk("psc.final", int'(q_p), 4);

    // Async reset between edges, mid-prescale.
    drive(0, 1, 0, 1, 5); tick();
    chk("arst.pre", int'(q_w), 5);
    drive(0, 0, 1, 1, 0); tick();
    #2 rst = 1'b0;
    #1 model_reset();
    chk("arst.Q", int'(q_w), 0); chk("arst.tc", int'(tc_w), 0); chk("arst.ovf", int'(ovf_w), 0);
    chk("arst.psc.Q", int'(q_p), 0);
    tick(); tick();
    chk("arst.held", int'(q_w), 0);
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      clr  = ($urandom_range(0, 39) == 0);
      load = ($urandom_range(0, 19) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = ($urandom_range(0, 4) != 0) ? ((i / 200) % 2 == 0) : ~((i / 200) % 2 == 0);
      lv   = 4'($urandom_range(0, 15));
      rst  = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
Parametrised up/down counter, successor to the fixed 16-bit enable counter. Adds:
- configurable width and modulus
- direction control
- synchronous clear and parallel load
- wrap or saturate mode
- enable prescaler
- terminal-count pulse and sticky overflow flag

Used as a general timer/event counter in lab datapaths.

Parameters:
WIDTH, 16, counter width in bits (>=2)
MOD_MAX, 2**WIDTH-1, terminal value; count range 0..MOD_MAX; must satisfy 1 <= MOD_MAX <= 2**WIDTH-1
SATURATE, 0, 0 = wrap at boundary, 1 = hold at boundary
PRESCALE, 1, number of enabled cycles per count step (>=1); 1 = step on every enabled cycle

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
en  input  1  count enable, feeds the prescaler
up  input  1  direction: 1 = increment, 0 = decrement
clr  input  1  synchronous clear
load  input  1  synchronous parallel load
load_val  input  WIDTH  value to load
Q  output  WIDTH  current count, registered
tc  output  1  terminal-count pulse, registered, one cycle wide per boundary event
ovf  output  1  sticky flag: set on any boundary event, cleared by rst or clr

Behaviour:
- Reset: asynchronous, active-low.
  - While rst=0: Q=0, tc=0, ovf=0, internal prescaler psc=0, regardless of clk.
  - Release takes effect at the next rising edge.
- All other updates occur on the rising edge of clk. Q reflects an operation one edge after inputs are sampled.
- Priority per edge: clr > load > count step > hold.
- clr=1:
  - Q<=0, psc<=0, ovf<=0, tc<=0.
  - en, load and up are ignored.
- load=1 (clr=0):
  - Q<=load_val if load_val<=MOD_MAX, else Q<=MOD_MAX (clamped).
  - psc<=0, tc<=0, ovf unchanged.
- Prescaler, when clr=0 and load=0:
  - en=0: psc and Q hold; tc<=0.
  - en=1 and psc<PRESCALE-1: psc<=psc+1, Q holds, tc<=0.
  - en=1 and psc==PRESCALE-1: psc<=0 and a count step occurs.
  - With PRESCALE=1, every enabled edge is a step.
- Count step, up=1:
  - Q<MOD_MAX: Q<=Q+1, tc<=0.
  - Q==MOD_MAX (boundary event): Q<=0 if SATURATE=0, Q holds MOD_MAX if SATURATE=1; tc<=1, ovf<=1.
- Count step, up=0:
  - Q>0: Q<=Q-1, tc<=0.
  - Q==0 (boundary event): Q<=MOD_MAX if SATURATE=0, Q holds 0 if SATURATE=1; tc<=1, ovf<=1.
- tc:
  - High for exactly the one cycle following an edge with a boundary event.
  - Back-to-back boundary events (saturate mode, PRESCALE=1) keep tc high continuously.
  - Forced low on any non-step edge.
- Direction may change on any cycle. Only the value of up sampled at the step edge matters; the prescaler phase is unaffected.
- ovf:
  - Set on any boundary event in either mode.
  - Held until clr=1 or rst=0.
  - load does not clear it.
- Q never exceeds MOD_MAX under any input sequence.
- Arithmetic is WIDTH bits with no carry-out port. The wrap target is MOD_MAX or 0, never 2**WIDTH-1 unless MOD_MAX equals it.
- Reset mid-operation, including mid-prescale: all state returns to 0 immediately. No partial step survives.

Test Plan:
1. Async reset (WIDTH=4, MOD_MAX=9): count to Q=5, drive rst=0 between clock edges -> Q=0, tc=0, ovf=0 before the next edge; Q stays 0 while rst=0.
2. Up wrap (WIDTH=4, MOD_MAX=9, PRESCALE=1): load 8, then en=1, up=1 -> Q sequence 9, 0, 1; tc=1 for only the cycle after the 9->0 edge; ovf=1 and stays 1.
3. Down wrap and clr: load 1, en=1, up=0 -> Q sequence 0, 9, 8; tc pulses once after the 0->9 edge. Then clr=1 -> Q=0, ovf=0.
4. Saturate (SATURATE=1, MOD_MAX=9): load 9, en=1, up=1 for 3 cycles -> Q holds 9, tc=1 on all 3 cycles, ovf=1. Switch up=0 -> Q=8, tc=0.
5. Prescaler (PRESCALE=3): en=1 for 9 edges from Q=0 -> Q=3. en=1 for 2 edges, en=0 for 4 edges, en=1 for 1 edge -> Q increments exactly once, on the final edge.
6. Priority and clamp: clr=1, load=1, en=1 on the same edge -> Q=0. Then load=1, load_val=12, MOD_MAX=9 -> Q=9, psc reset, ovf unchanged.
